lfclk_gen: RTL and testbench



---
 rtl/lfclk_gen.sv | 133 +++++++++++++
 tb/tb_lfclk_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lfclk_gen.sv
// Low-frequency clock generator: an NCO accumulator toggles lfclk_o so the long-term
// rate is exactly OUT_HZ, with run/drain control and rise / one-second strobes.
module lfclk_gen #(
  parameter int IN_HZ  = 16000000,
  parameter int OUT_HZ = 32768,
  parameter int ACC_W  = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic lfclk_o,
  output logic rise_o,
  output logic sec_o,
  output logic running_o
);

  localparam int SEC_W = (OUT_HZ > 1) ? $clog2(OUT_HZ) : 1;
  localparam logic [ACC_W-1:0] INC     = ACC_W'(2 * OUT_HZ);
  localparam logic [ACC_W-1:0] TOP     = ACC_W'(IN_HZ);
  localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(OUT_HZ - 1);

  if (2 * OUT_HZ >= IN_HZ) begin : g_bad_ratio
    $error("lfclk_gen: 2*OUT_HZ must be below IN_HZ");
  end
  if ((64'd1 << ACC_W) <= (64'(IN_HZ) + 64'(2 * OUT_HZ))) begin : g_bad_width
    $error("lfclk_gen: ACC_W too narrow for IN_HZ + 2*OUT_HZ");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] nxt_s;
  logic             wrap_s;
  logic             lfclk_q, lfclk_d;
  logic             rise_q, rise_d;
  logic             sec_q, sec_d;
  logic             running_q, running_d;
  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;

  // Candidate accumulator value and half-period boundary detect
  always_comb begin
    nxt_s  = acc_q + INC;
    wrap_s = (nxt_s >= TOP);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stopping only lands in IDLE once lfclk would be low
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
        else    state_d = S_IDLE;
      end
      S_RUN: begin
        if (en)                     state_d = S_RUN;
        else if (lfclk_q ^ wrap_s)  state_d = S_DRAIN;
        else                        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (en)          state_d = S_RUN;
        else if (wrap_s) state_d = S_IDLE;
        else             state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: accumulator, output phase, strobes and second counter
  always_comb begin
    acc_d     = acc_q;
    lfclk_d   = lfclk_q;
    sec_cnt_d = sec_cnt_q;
    sec_d     = 1'b0;
    if (state_d == S_IDLE) begin
      acc_d   = '0;
      lfclk_d = 1'b0;
    end else begin
      acc_d   = wrap_s ? (nxt_s - TOP) : nxt_s;
      lfclk_d = lfclk_q ^ wrap_s;
    end
    rise_d = lfclk_d & ~lfclk_q;
    if (rise_d) begin
      if (sec_cnt_q == SEC_MAX) begin
        sec_cnt_d = '0;
        sec_d     = 1'b1;
      end else begin
        sec_cnt_d = sec_cnt_q + SEC_W'(1);
      end
    end else begin
      sec_cnt_d = sec_cnt_q;
    end
    running_d = (state_q != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      lfclk_q   <= 1'b0;
      rise_q    <= 1'b0;
      sec_q     <= 1'b0;
      running_q <= 1'b0;
      sec_cnt_q <= '0;
    end else begin
      acc_q     <= acc_d;
      lfclk_q   <= lfclk_d;
      rise_q    <= rise_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      sec_cnt_q <= sec_cnt_d;
    end
  end

  assign lfclk_o   = lfclk_q;
  assign rise_o    = rise_q;
  assign sec_o     = sec_q;
  assign running_o = running_q;

endmodule

// File: tb/tb_lfclk_gen.sv
// Directed bench for lfclk_gen: default-parameter phase/control vectors plus a
// small-parameter instance for the one-second strobe and async reset behaviour.
module tb_lfclk_gen;

  typedef struct {
    logic en;
    int   n;
    logic lf;
    logic rise;
    logic run;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, en, lfclk, rise, sec, running;
  logic rst2_n, en2, lf2, rise2, sec2, run2;
  int   total = 0;
  int   bad   = 0;
  int   rises2 = 0;
  vec_t vecs[31];

  always #5 clk = ~clk;

  lfclk_gen u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .lfclk_o(lfclk), .rise_o(rise), .sec_o(sec), .running_o(running)
  );

  // Small instance: INC=8, half period 12/13 cycles, sec_o every 4th rise
  lfclk_gen #(.IN_HZ(100), .OUT_HZ(4), .ACC_W(8)) u_small (
    .clk(clk), .rst_n(rst2_n), .en(en2),
    .lfclk_o(lf2), .rise_o(rise2), .sec_o(sec2), .running_o(run2)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the small instance until its cumulative rise count reaches upto
  task automatic run_small(input int upto);
    int guard;
    guard = 0;
    while (rises2 < upto && guard < 60 * upto + 100) begin
      step(1);
      guard++;
      if (rise2) begin
        rises2++;
        chk("sec2_at_rise", sec2, ((rises2 % 4) == 0) ? 1'b1 : 1'b0);
        chk("lf2_high_at_rise", lf2, 1'b1);
      end else begin
        chk("sec2_idle", sec2, 1'b0);
      end
    end
    if (rises2 < upto) begin
      total++;
      bad++;
      $display("FAIL small_timeout: got %0d rises expected %0d", rises2, upto);
    end
  endtask

  initial begin
    vecs = '{
      '{1'b0,   3, 1'b0, 1'b0, 1'b0},
      '{1'b1,   1, 1'b0, 1'b0, 1'b0},
      '{1'b1,   1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 242, 1'b0, 1'b0, 1'b1},
      '{1'b1,   1, 1'b1, 1'b1, 1'b1},
      '{1'b1,   1, 1'b1, 1'b0, 1'b1},
      '{1'b1, 242, 1'b1, 1'b0, 1'b1},
      '{1'b1,   1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 243, 1'b0, 1'b0, 1'b1},
      '{1'b1,   1, 1'b1, 1'b1, 1'b1},
      '{1'b1,   9, 1'b1, 1'b0, 1'b1},
      '{1'b0,   1, 1'b1, 1'b0, 1'b1},
      '{1'b0, 233, 1'b1, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 244, 1'b0, 1'b0, 1'b1},
      '{1'b1,   1, 1'b1, 1'b1, 1'b1},
      '{1'b1, 244, 1'b0, 1'b0, 1'b1},
      '{1'b1,   5, 1'b0, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b0},
      '{1'b1, 244, 1'b0, 1'b0, 1'b1},
      '{1'b1,   1, 1'b1, 1'b1, 1'b1},
      '{1'b1,  10, 1'b1, 1'b0, 1'b1},
      '{1'b0,  20, 1'b1, 1'b0, 1'b1},
      '{1'b1, 213, 1'b1, 1'b0, 1'b1},
      '{1'b1,   1, 1'b0, 1'b0, 1'b1},
      '{1'b1, 244, 1'b1, 1'b1, 1'b1},
      '{1'b1, 243, 1'b1, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b1},
      '{1'b0,   1, 1'b0, 1'b0, 1'b0}
    };

    rst_n  = 1'b0;
    en     = 1'b0;
    rst2_n = 1'b0;
    en2    = 1'b0;
    step(3);
    chk("rst_lfclk", lfclk, 1'b0);
    chk("rst_rise", rise, 1'b0);
    chk("rst_sec", sec, 1'b0);
    chk("rst_running", running, 1'b0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      en = vecs[i].en;
      step(vecs[i].n);
      chk($sformatf("v%0d_lfclk", i), lfclk, vecs[i].lf);
      chk($sformatf("v%0d_rise", i), rise, vecs[i].rise);
      chk($sformatf("v%0d_running", i), running, vecs[i].run);
      chk($sformatf("v%0d_sec", i), sec, 1'b0);
    end

    // Async reset mid-high phase on the default instance
    en = 1'b1;
    step(250);
    chk("pre_rst_lfclk", lfclk, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lfclk", lfclk, 1'b0);
    chk("arst_rise", rise, 1'b0);
    chk("arst_running", running, 1'b0);
    chk("arst_sec", sec, 1'b0);
    en = 1'b0;
    step(2);
    rst_n = 1'b1;

    // One-second strobe, preserved across stop/start
    en2 = 1'b1;
    run_small(6);
    en2 = 1'b0;
    step(40);
    chk("small_stop_lf", lf2, 1'b0);
    chk("small_stop_run", run2, 1'b0);
    en2 = 1'b1;
    run_small(9);
    step(3);
    chk("small_pre_rst_lf", lf2, 1'b1);
    #2;
    rst2_n = 1'b0;
    #1;
    chk("small_arst_lf", lf2, 1'b0);
    chk("small_arst_rise", rise2, 1'b0);
    chk("small_arst_sec", sec2, 1'b0);
    chk("small_arst_run", run2, 1'b0);
    step(2);
    rst2_n = 1'b1;
    rises2 = 0;
    run_small(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
